vga_tile_reveal: RTL and testbench

Parametrised tile-reveal compositor for the VGA pipeline. It sits between the VGA timing generator plus image/palette RAMs and the VGA pins. It divides the screen into a COLS x ROWS grid and reveals game-image tiles in raster order as the score rises, fading each newly revealed tile in over several frames. Score and mode are sampled only at frame boundaries so the picture never tears. Out of game it shows the end-screen image.

---
 rtl/vga_tile_reveal.sv | 118 +++++++++++
 tb/tb_vga_tile_reveal.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vga_tile_reveal.sv
// vga_tile_reveal: grid tile-reveal compositor that fades in newly revealed tiles between the VGA timing source and the pins.
module vga_tile_reveal #(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int COLS = 4,
  parameter int ROWS = 3,
  parameter int PIPE_LAT = 2,
  parameter int FADE_SHIFT = 3,
  parameter logic [11:0] HIDDEN_COLOR = 12'h000,
  localparam int N = COLS * ROWS,
  localparam int RW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    x,
  input  logic [8:0]    y,
  input  logic          active,
  input  logic          screenEnd,
  input  logic          ingame,
  input  logic [31:0]   score,
  input  logic [11:0]   gameColor,
  input  logic [11:0]   endColor,
  output logic [11:0]   rgb,
  output logic [RW-1:0] revealed,
  output logic          fading
);
  localparam int TW = WIDTH / COLS;
  localparam int TH = HEIGHT / ROWS;
  localparam int LW = FADE_SHIFT + 1;
  localparam logic [LW-1:0] FULL = LW'(2 ** FADE_SHIFT);
  typedef enum logic {END_S, GAME_S} state_t;
  state_t state, state_n;
  logic [RW-1:0] prev, prev_n, rev_n, target, idx;
  logic [LW-1:0] lvl, lvl_n;
  logic fad_n;
  logic [9:0] xq [PIPE_LAT];
  logic [8:0] yq [PIPE_LAT];
  logic [PIPE_LAT-1:0] aq;
  logic [3:0] col, row;
  logic [11:0] pix, rgb_n;
  function automatic logic [3:0] fch(input logic [3:0] c, input logic [LW-1:0] l);
    logic [LW+3:0] p;
    p = c * l;
    return p[FADE_SHIFT +: 4];
  endfunction
  always_ff @(posedge clk) begin
    xq[0] <= x;
    yq[0] <= y;
    aq[0] <= reset & active;
    for (int i = 1; i < PIPE_LAT; i++) begin
      xq[i] <= xq[i-1];
      yq[i] <= yq[i-1];
      aq[i] <= reset & aq[i-1];
    end
  end
  // comparator chains replace the divide by tile size
  always_comb begin
    col = '0;
    row = '0;
    for (int k = 1; k < COLS; k++) if (xq[PIPE_LAT-1] >= 10'(k * TW)) col = col + 4'd1;
    for (int k = 1; k < ROWS; k++) if (yq[PIPE_LAT-1] >= 9'(k * TH)) row = row + 4'd1;
    idx = RW'(row * COLS + col);
    pix = idx < prev ? gameColor :
          idx < revealed ? {fch(gameColor[11:8], lvl), fch(gameColor[7:4], lvl), fch(gameColor[3:0], lvl)} :
          HIDDEN_COLOR;
    rgb_n = !aq[PIPE_LAT-1] ? 12'h000 : state == END_S ? endColor : pix;
  end
  always_comb begin
    target = score >= 32'(N) ? RW'(N) : score[RW-1:0];
    state_n = state;
    rev_n = revealed;
    prev_n = prev;
    lvl_n = lvl;
    fad_n = fading;
    if (screenEnd) begin
      if (state == END_S) begin
        if (ingame) begin
          state_n = GAME_S;
          rev_n = '0;
          prev_n = '0;
          lvl_n = '0;
          fad_n = 1'b0;
        end
      end else if (!ingame) state_n = END_S;
      else if (target > revealed) begin
        prev_n = revealed;
        rev_n = target;
        lvl_n = FADE_SHIFT == 0 ? FULL : '0;
        fad_n = FADE_SHIFT != 0;
      end else if (target < revealed) begin
        rev_n = target;
        prev_n = target;
        lvl_n = FULL;
        fad_n = 1'b0;
      end else if (fading) begin
        fad_n = lvl != FULL;
        lvl_n = lvl == FULL ? lvl : lvl + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= END_S;
      revealed <= '0;
      prev <= '0;
      lvl <= FULL;
      fading <= 1'b0;
      rgb <= '0;
    end else begin
      state <= state_n;
      revealed <= rev_n;
      prev <= prev_n;
      lvl <= lvl_n;
      fading <= fad_n;
      rgb <= rgb_n;
    end
  end
endmodule

// File: tb/tb_vga_tile_reveal.sv
// tb_vga_tile_reveal: directed checks of three grid/fade configurations sharing one stimulus stream.
module tb_vga_tile_reveal;
  logic clk = 0, reset = 0, active = 0, screenEnd = 0, ingame = 0;
  logic [9:0] x = 0;
  logic [8:0] y = 0;
  logic [31:0] score = 0;
  logic [11:0] gameColor = 0, endColor = 0;
  logic [11:0] rgb0, rgb3, rgb8, s0, s3, s8;
  logic [3:0] revealed0, revealed3;
  logic [5:0] revealed8;
  logic fading0, fading3, fading8;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  vga_tile_reveal #(.FADE_SHIFT(0)) dut0 (.clk(clk), .reset(reset), .x(x), .y(y), .active(active),
    .screenEnd(screenEnd), .ingame(ingame), .score(score), .gameColor(gameColor), .endColor(endColor),
    .rgb(rgb0), .revealed(revealed0), .fading(fading0));
  vga_tile_reveal #(.FADE_SHIFT(3)) dut3 (.clk(clk), .reset(reset), .x(x), .y(y), .active(active),
    .screenEnd(screenEnd), .ingame(ingame), .score(score), .gameColor(gameColor), .endColor(endColor),
    .rgb(rgb3), .revealed(revealed3), .fading(fading3));
  vga_tile_reveal #(.COLS(8), .ROWS(6), .FADE_SHIFT(0)) dut8 (.clk(clk), .reset(reset), .x(x), .y(y),
    .active(active), .screenEnd(screenEnd), .ingame(ingame), .score(score), .gameColor(gameColor),
    .endColor(endColor), .rgb(rgb8), .revealed(revealed8), .fading(fading8));
  task pix(input logic [9:0] px, input logic [8:0] py, input logic act);
    @(negedge clk);
    x = px;
    y = py;
    active = act;
    repeat (3) @(posedge clk);
    #1;
    s0 = rgb0;
    s3 = rgb3;
    s8 = rgb8;
  endtask
  task pulse;
    @(negedge clk);
    active = 0;
    screenEnd = 1;
    @(negedge clk);
    screenEnd = 0;
  endtask
  task test_reset;
    reset = 0; ingame = 0; endColor = 12'hABC; gameColor = 12'hFFF; active = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (rgb0 !== 12'h000) begin errors++; $display("FAIL reset_rgb cycle%0d rgb=%h expected 000", i, rgb0); end
    end
    checks++; if (revealed0 !== 4'd0 || fading3 !== 1'b0) begin errors++; $display("FAIL reset_state revealed=%0d fading=%b expected 0 0", revealed0, fading3); end
    @(negedge clk); reset = 1; active = 0;
    repeat (3) @(negedge clk);
    active = 1;
    @(negedge clk); active = 0;
    @(posedge clk); #1;
    checks++; if (rgb0 !== 12'h000) begin errors++; $display("FAIL latency_early rgb=%h expected 000", rgb0); end
    @(posedge clk); #1;
    checks++; if (rgb0 !== 12'hABC) begin errors++; $display("FAIL latency_hit rgb=%h expected abc", rgb0); end
    @(posedge clk); #1;
    checks++; if (rgb0 !== 12'h000) begin errors++; $display("FAIL latency_after rgb=%h expected 000", rgb0); end
    pix(100, 100, 1);
    checks++; if (s0 !== 12'hABC) begin errors++; $display("FAIL end_screen rgb=%h expected abc", s0); end
    pix(100, 100, 0);
    checks++; if (s0 !== 12'h000) begin errors++; $display("FAIL end_blank rgb=%h expected 000", s0); end
  endtask
  task test_mode_entry;
    ingame = 1; score = 0;
    pulse;
    pix(0, 0, 1);
    checks++; if (s0 !== 12'h000) begin errors++; $display("FAIL entry_hidden rgb=%h expected 000", s0); end
    pix(639, 479, 1);
    checks++; if (s0 !== 12'h000) begin errors++; $display("FAIL entry_hidden_corner rgb=%h expected 000", s0); end
    score = 1;
    pulse;
    checks++; if (revealed0 !== 4'd1 || fading0 !== 1'b0) begin errors++; $display("FAIL entry_count revealed=%0d fading=%b expected 1 0", revealed0, fading0); end
    pix(0, 0, 1);
    checks++; if (s0 !== 12'hFFF) begin errors++; $display("FAIL tile0_origin rgb=%h expected fff", s0); end
    pix(159, 159, 1);
    checks++; if (s0 !== 12'hFFF) begin errors++; $display("FAIL tile0_corner rgb=%h expected fff", s0); end
    pix(160, 0, 1);
    checks++; if (s0 !== 12'h000) begin errors++; $display("FAIL tile1_hidden rgb=%h expected 000", s0); end
    pix(0, 160, 1);
    checks++; if (s0 !== 12'h000) begin errors++; $display("FAIL tile4_hidden rgb=%h expected 000", s0); end
    pix(0, 0, 0);
    checks++; if (s0 !== 12'h000) begin errors++; $display("FAIL game_blank rgb=%h expected 000", s0); end
  endtask
  task test_fade;
    logic [11:0] tbl [9];
    tbl = '{12'h000, 12'h110, 12'h231, 12'h351, 12'h472, 12'h592, 12'h6B3, 12'h7D3, 12'h8F4};
    gameColor = 12'h8F4; score = 1;
    ingame = 0; pulse;
    ingame = 1; pulse;
    pulse;
    for (int l = 0; l < 9; l++) begin
      pix(10, 10, 1);
      checks++; if (s3 !== tbl[l]) begin errors++; $display("FAIL fade_lvl%0d rgb=%h expected %h", l, s3, tbl[l]); end
      checks++; if (fading3 !== 1'b1) begin errors++; $display("FAIL fading_lvl%0d fading=%b expected 1", l, fading3); end
      pulse;
    end
    checks++; if (fading3 !== 1'b0) begin errors++; $display("FAIL fade_done fading=%b expected 0", fading3); end
    pix(10, 10, 1);
    checks++; if (s3 !== 12'h8F4) begin errors++; $display("FAIL fade_hold rgb=%h expected 8f4", s3); end
  endtask
  task test_saturation;
    score = 32'hFFFF_FFFF;
    pulse;
    checks++; if (revealed0 !== 4'd12 || revealed8 !== 6'd48) begin errors++; $display("FAIL sat_count revealed=%0d,%0d expected 12,48", revealed0, revealed8); end
    checks++; if (fading3 !== 1'b1) begin errors++; $display("FAIL sat_fading fading=%b expected 1", fading3); end
    pix(639, 479, 1);
    checks++; if (s0 !== 12'h8F4) begin errors++; $display("FAIL sat_last_tile rgb=%h expected 8f4", s0); end
    score = 5;
    pulse;
    checks++; if (revealed0 !== 4'd5 || revealed3 !== 4'd5) begin errors++; $display("FAIL drop_count revealed=%0d,%0d expected 5,5", revealed0, revealed3); end
    checks++; if (fading3 !== 1'b0) begin errors++; $display("FAIL drop_fading fading=%b expected 0", fading3); end
    pix(0, 160, 1);
    checks++; if (s0 !== 12'h8F4 || s3 !== 12'h8F4) begin errors++; $display("FAIL drop_tile4 rgb=%h,%h expected 8f4,8f4", s0, s3); end
    pix(160, 160, 1);
    checks++; if (s0 !== 12'h000) begin errors++; $display("FAIL drop_tile5 rgb=%h expected 000", s0); end
    pix(600, 400, 1);
    checks++; if (s3 !== 12'h000) begin errors++; $display("FAIL drop_tile11 rgb=%h expected 000", s3); end
  endtask
  task test_midframe;
    pix(200, 200, 1);
    checks++; if (s0 !== 12'h000) begin errors++; $display("FAIL mid_before rgb=%h expected 000", s0); end
    score = 12;
    pix(200, 200, 1);
    checks++; if (s0 !== 12'h000) begin errors++; $display("FAIL mid_after_change rgb=%h expected 000", s0); end
    pix(639, 479, 1);
    checks++; if (s0 !== 12'h000 || revealed0 !== 4'd5) begin errors++; $display("FAIL mid_frozen rgb=%h revealed=%0d expected 000 5", s0, revealed0); end
    pulse;
    pix(200, 200, 1);
    checks++; if (s0 !== 12'h8F4 || revealed0 !== 4'd12) begin errors++; $display("FAIL mid_next_frame rgb=%h revealed=%0d expected 8f4 12", s0, revealed0); end
  endtask
  task test_grid;
    score = 9;
    pulse;
    checks++; if (revealed8 !== 6'd9) begin errors++; $display("FAIL grid_count revealed=%0d expected 9", revealed8); end
    pix(639, 0, 1);
    checks++; if (s8 !== 12'h8F4) begin errors++; $display("FAIL grid_tile7 rgb=%h expected 8f4", s8); end
    pix(79, 80, 1);
    checks++; if (s8 !== 12'h8F4) begin errors++; $display("FAIL grid_tile8 rgb=%h expected 8f4", s8); end
    pix(80, 80, 1);
    checks++; if (s8 !== 12'h000) begin errors++; $display("FAIL grid_tile9 rgb=%h expected 000", s8); end
    pix(0, 160, 1);
    checks++; if (s8 !== 12'h000) begin errors++; $display("FAIL grid_tile16 rgb=%h expected 000", s8); end
  endtask
  task test_reset_midframe;
    pix(0, 0, 1);
    @(negedge clk); reset = 0; screenEnd = 1;
    @(posedge clk); #1;
    checks++; if (rgb0 !== 12'h000 || revealed0 !== 4'd0 || fading3 !== 1'b0) begin errors++; $display("FAIL midreset rgb=%h revealed=%0d fading=%b expected 000 0 0", rgb0, revealed0, fading3); end
    @(negedge clk); reset = 1; screenEnd = 0;
    @(posedge clk); #1;
    checks++; if (rgb0 !== 12'h000) begin errors++; $display("FAIL midreset_flush rgb=%h expected 000", rgb0); end
    pix(0, 0, 1);
    checks++; if (s0 !== 12'hABC) begin errors++; $display("FAIL midreset_end rgb=%h expected abc", s0); end
  endtask
  initial begin
    #5000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_mode_entry;
    test_fade;
    test_saturation;
    test_midframe;
    test_grid;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
